// File: rtl/uart_pkg.sv
// Shared register map, STATUS bit positions and the state type used by both
// serial engines of the uart peripheral.
package uart_pkg;

  localparam logic [1:0] UART_DATA   = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_DIV    = 2'd2;

  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_TX_BUSY      = 2;
  localparam int ST_RX_VALID     = 3;
  localparam int ST_RX_OVERRUN   = 4;
  localparam int ST_RX_FRAME_ERR = 5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  // (d+1)/2 without losing the carry when d is all ones
  function automatic logic [15:0] half_period(input logic [15:0] d);
    logic [16:0] p;
    p = {1'b0, d} + 17'd1;
    return p[16:1];
  endfunction

endpackage

// File: rtl/uart_if.sv
// Peripheral-window bus between the memory decoder and the uart slave.
interface uart_if #(parameter int width = 16) ();
  logic [1:0]       addr;
  logic [width-1:0] data_write;
  logic             w_strobe;
  logic [width-1:0] data_read;

  modport master (output addr, output data_write, output w_strobe, input data_read);
  modport slave  (input addr, input data_write, input w_strobe, output data_read);
endinterface

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with extra-MSB pointers; full/empty come straight
// from the pointer compare.
module uart_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push,
  input  logic [width-1:0] din,
  input  logic             pop,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int aw = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [aw:0]      wr_ptr;
  logic [aw:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot the push needs
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[aw-1:0]];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[aw-1:0]] <= din;
  end

endmodule

// File: rtl/uart.sv
// Byte UART slave: TX FIFO feeding a serialiser, single-entry RX holding
// register, programmable divisor; bit period is div+1 clocks.
//
// state | meaning
// IDLE  | line idle, waiting for a FIFO byte (TX) or a falling edge (RX)
// START | start bit; RX checks it at mid-bit and rejects glitches
// DATA  | eight data bits, LSB first
// STOP  | stop bit; TX chains the next byte, RX delivers or flags framing
module uart
  import uart_pkg::*;
#(
  parameter int          width       = 16,
  parameter int          fifo_depth  = 4,
  parameter logic [15:0] default_div = 16'd433
) (
  input  logic  clk,
  input  logic  reset,
  uart_if.slave bus,
  input  logic  rx,
  output logic  tx
);

  logic [15:0] div;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]  tx_dout;

  uart_state_e tx_state;
  logic [15:0] tx_cnt, tx_div;
  logic [7:0]  tx_shift;
  logic [2:0]  tx_bit;

  uart_state_e rx_state;
  logic        rx_meta, rx_sync, rx_prev;
  logic [15:0] rx_cnt, rx_div;
  logic [7:0]  rx_shift;
  logic [2:0]  rx_bit;
  logic        rx_done, rx_ferr;

  logic        rx_valid, rx_overrun, rx_frame_err;
  logic [7:0]  rx_byte;
  logic        st_wr, div_wr;
  logic        clr_valid, clr_overrun, clr_ferr;
  logic [width-1:0] rd_next;

  assign tx_push     = bus.w_strobe && (bus.addr == UART_DATA);
  assign st_wr       = bus.w_strobe && (bus.addr == UART_STATUS);
  assign div_wr      = bus.w_strobe && (bus.addr == UART_DIV);
  assign clr_valid   = st_wr && bus.data_write[0];
  assign clr_overrun = st_wr && bus.data_write[1];
  assign clr_ferr    = st_wr && bus.data_write[2];

  assign tx_pop = !tx_empty &&
                  ((tx_state == IDLE) || ((tx_state == STOP) && (tx_cnt == 16'd0)));

  uart_fifo #(.width(8), .depth(fifo_depth)) u_tx_fifo (
    .clk   (clk),
    .rst_b (reset),
    .push  (tx_push),
    .din   (bus.data_write[7:0]),
    .pop   (tx_pop),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= IDLE;
      tx       <= 1'b1;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_shift <= '0;
      tx_bit   <= '0;
    end else if (tx_pop) begin
      tx_state <= START;
      tx       <= 1'b0;
      tx_shift <= tx_dout;
      tx_div   <= div;
      tx_cnt   <= div;
    end else begin
      case (tx_state)
        START: begin
          if (tx_cnt == 16'd0) begin
            tx_state <= DATA;
            tx       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= '0;
            tx_cnt   <= tx_div;
          end else tx_cnt <= tx_cnt - 16'd1;
        end
        DATA: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt <= tx_div;
            if (tx_bit == 3'd7) begin
              tx_state <= STOP;
              tx       <= 1'b1;
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 3'd1;
            end
          end else tx_cnt <= tx_cnt - 16'd1;
        end
        STOP: begin
          if (tx_cnt == 16'd0) tx_state <= IDLE;
          else                 tx_cnt   <= tx_cnt - 16'd1;
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // after a framing error the edge detector needs the line high again before
  // another start can be seen, so IDLE is entered directly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_shift <= '0;
      rx_bit   <= '0;
      rx_done  <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      rx_ferr <= 1'b0;
      case (rx_state)
        IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= START;
            rx_div   <= div;
            rx_cnt   <= half_period(div);
          end
        end
        START: begin
          if (rx_cnt == 16'd0) begin
            rx_state <= rx_sync ? IDLE : DATA;
            rx_cnt   <= rx_div;
            rx_bit   <= '0;
          end else rx_cnt <= rx_cnt - 16'd1;
        end
        DATA: begin
          if (rx_cnt == 16'd0) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_cnt   <= rx_div;
            if (rx_bit == 3'd7) rx_state <= STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt - 16'd1;
        end
        STOP: begin
          if (rx_cnt == 16'd0) begin
            rx_state <= IDLE;
            if (rx_sync) rx_done <= 1'b1;
            else         rx_ferr <= 1'b1;
          end else rx_cnt <= rx_cnt - 16'd1;
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div          <= default_div;
      rx_valid     <= 1'b0;
      rx_byte      <= '0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (div_wr) div <= bus.data_write[15:0];
      if (clr_overrun) rx_overrun <= 1'b0;
      if (clr_ferr) rx_frame_err <= 1'b0;
      if (rx_ferr) rx_frame_err <= 1'b1;
      // a consume in the same cycle makes room for the arriving byte
      if (rx_done) begin
        if (rx_valid && !clr_valid) rx_overrun <= 1'b1;
        else begin
          rx_valid <= 1'b1;
          rx_byte  <= rx_shift;
        end
      end else if (clr_valid) rx_valid <= 1'b0;
    end
  end

  always_comb begin
    rd_next = '0;
    case (bus.addr)
      UART_DATA: begin
        rd_next[8]   = rx_valid;
        rd_next[7:0] = rx_byte;
      end
      UART_STATUS: begin
        rd_next[ST_TX_FULL]      = tx_full;
        rd_next[ST_TX_EMPTY]     = tx_empty;
        rd_next[ST_TX_BUSY]      = (tx_state != IDLE);
        rd_next[ST_RX_VALID]     = rx_valid;
        rd_next[ST_RX_OVERRUN]   = rx_overrun;
        rd_next[ST_RX_FRAME_ERR] = rx_frame_err;
      end
      UART_DIV: rd_next[15:0] = div;
      default:  rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bus.data_read <= '0;
    else        bus.data_read <= rd_next;
  end

endmodule

// File: doc/uart.md
Name: uart

Overview:
- Byte-oriented UART peripheral that sits directly downstream of the memory bus decoder, on the next free peripheral window (addr 9'b1_0000_001x and up, local addr[1:0]).
- Same slave contract as the RAM and GPIO slaves: addr/data_write/w_strobe in; data_read registered with one-cycle latency.
- Provides a TX FIFO, a single-entry RX holding register, and a programmable baud divisor, so the CPU can do serial console I/O without cycle-counting.

Parameters:
- width, 16, bus data width; must be >= 16.
- fifo_depth, 4, TX FIFO entries; power of two, >= 2.
- default_div, 16'd433, reset value of the baud divisor. Bit period = div+1 clocks (50 MHz / 115200).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- data_write  input  width  write data from the bus.
- data_read  output  width  registered read data; reflects addr of the previous cycle.
- addr  input  2  local register select.
- w_strobe  input  1  write enable, already qualified by the decoder select.
- rx  input  1  serial input, asynchronous to clk; idle high.
- tx  output  1  serial output; idle high.

Behaviour:
- Register map, addr 0, DATA:
  - Write: push data_write[7:0] into the TX FIFO. If the FIFO is full, the write is dropped with no state change.
  - Read: {rx_valid in bit 8, rx_byte in [7:0]}; other bits 0.
- Register map, addr 1, STATUS:
  - Read bits: [0] tx_full, [1] tx_empty, [2] tx_busy (shifter active), [3] rx_valid, [4] rx_overrun, [5] rx_frame_err; other bits 0.
  - Write, bit0=1: clear rx_valid (consume byte). bit1=1: clear rx_overrun. bit2=1: clear rx_frame_err. Bits written as 0 have no effect.
- Register map, addr 2, DIV: read/write 16-bit divisor; upper bits beyond 16 read 0.
- Register map, addr 3: reads 0; writes ignored.
- Reads have no side effects. data_read updates every cycle from the addr sampled on that edge.
- Reset values: tx=1, data_read=0, FIFO empty, rx_valid, rx_overrun and rx_frame_err all 0, DIV=default_div, both FSMs IDLE.
- Reset mid-frame: tx returns to 1 asynchronously; the partially sent or received frame is lost.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE with FIFO non-empty: pop, latch byte and DIV, go START.
  - Each state lasts div+1 clocks.
  - DATA shifts 8 bits LSB first, with tx = current bit.
  - STOP drives tx=1, then pops the next byte back-to-back if available (no idle gap); otherwise goes to IDLE.
  - tx is registered, with no glitches.
- DIV write timing: takes effect at the next frame start for each FSM; frames in flight are unaffected.
- RX synchronisation: rx passes through a 2-flop synchroniser before the FSM. Synchroniser and rx-input flops reset to 1.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: a falling edge on the synchronised rx enters START and latches DIV.
  - START: at (div+1)/2 clocks, sample. If high, it was a glitch; return to IDLE. Otherwise proceed.
  - DATA: sample every div+1 clocks, 8 bits LSB first.
  - STOP: sample once. If high, deliver the byte; if low, set rx_frame_err, discard the byte, and go to IDLE after the line returns high.
- Delivery when rx_valid=0: rx_byte <= byte, rx_valid <= 1.
- Delivery when rx_valid=1: rx_byte is kept, rx_overrun <= 1, new byte discarded.
- Simultaneous events:
  - A STATUS clear of rx_valid in the same cycle as a delivery: the delivery wins; rx_valid stays 1 and holds the new byte.
  - An error set and its clear in the same cycle: set wins.
  - FIFO push and pop in the same cycle when full: the pop happens and the push is accepted.
  - Push and pop in the same cycle when empty: no pop; the push is accepted.
- Counters: the baud counter is 16 bits and counts down from div to 0. div=0 gives a 1-clock bit period, which is legal. The FIFO uses log2(depth)+1 bit pointers; wrap is by natural overflow.

Decomposition:
- Package uart_pkg: register address localparams (UART_DATA=0, UART_STATUS=1, UART_DIV=2), STATUS bit-index localparams, and the shared state enum typedef (IDLE, START, DATA, STOP) used by both FSMs.
- One sub-module uart_fifo (width, depth): synchronous FIFO with push/pop/full/empty/dout. RX and TX FSMs stay inline.

Test Plan:
- Reset then read all addrs -> DATA=0, STATUS=16'h0002, DIV=433, tx=1 throughout.
- DIV=3, write DATA=8'hA5 -> tx low 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then stop high 4 clocks. tx_busy=1 during the frame; tx_empty=1 after the pop.
- DIV=3, write 5 bytes back-to-back with depth 4 -> the first pop frees a slot so all 5 are accepted. Writing 6 more while busy: the extra beyond full is dropped and tx_full=1. Frames are emitted with no idle gap between stop and start.
- DIV=7, drive rx with frame 8'h3C -> STATUS bit3=1, DATA reads 16'h013C. Send 8'h55 before clearing -> rx_overrun=1, DATA still 16'h013C. Write STATUS=3 -> both clear.
- Frame with stop bit 0 -> rx_frame_err=1, rx_valid unchanged. 2-clock low glitch on rx with DIV=7 -> no state change.
- Assert reset mid TX frame -> tx=1 immediately. After release: FIFO empty, DIV=433.
